mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 4K x 32 program memory between two requesters:
//  port 0 = cpu_top command engine, port 1 = debug/loader port.
//  Each cycle it selects at most one access: round-robin, plus a lock that
//  keeps the port for multi-access commands (ADD: rd,rd,wr; MUL: rd,rd,wr,wr).
//  It drives mem_addr/mem_wdata/mem_wen/mem_cen and routes mem_rdata back
//  to the requester that issued the read.
// PARAMETERS
//  ADDR_W    12  memory address width
//  DATA_W    32  memory data width
//  LOCK_MAX  4   max consecutive grants to one locked owner before forced release
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         synchronous, active-low reset
//  req         in   2         req[i]: port i has a valid access this cycle
//  lock        in   2         lock[i]: keep ownership after this access
//  req_wen     in   2         1 = write, 0 = read, per port
//  req_addr    in   2*ADDR_W  {addr1, addr0}
//  req_wdata   in   2*DATA_W  {wdata1, wdata0}
//  gnt         out  2         one-hot or zero; access accepted this cycle
//  rvalid      out  2         read data valid for port i
//  rdata       out  DATA_W    read data, qualified by rvalid
//  lock_err    out  1         1-cycle pulse on forced lock release
//  mem_addr    out  ADDR_W    to memory
//  mem_wdata   out  DATA_W    to memory
//  mem_rdata   in   DATA_W    from memory, valid 1 cycle after a read
//  mem_wen     out  1         1 = write (when mem_cen = 1)
//  mem_cen     out  1         1 = access this cycle
// BEHAVIOUR
//  - Reset (rst_n = 0 at posedge): gnt = 0, rvalid = 0, lock_err = 0,
//    mem_cen = 0, mem_wen = 0, rdata = 0, owner = NONE, last_gnt = 1
//    (port 0 wins first), lock_cnt = 0, read pipeline cleared.
//  - Handshake: port holds req/wen/addr/wdata stable until it samples gnt = 1.
//    gnt is combinational from req and registered state. The memory access
//    happens in the same cycle: mem_* = muxed fields of the granted port,
//    mem_cen = |gnt.
//  - States: IDLE (owner = NONE) and OWNED(i).
//    IDLE: if one port requests, grant it. If both request, grant
//    ~last_gnt. On a grant with lock[i] = 1, go to OWNED(i) with lock_cnt = 1.
//    OWNED(i): only port i may be granted; port ~i is masked.
//    On a grant to i with lock[i] = 1, lock_cnt++.
//    Release to IDLE when port i gives a granted access with lock[i] = 0,
//    or when port i drops both req and lock.
//    Forced release: a grant in OWNED(i) that brings lock_cnt to LOCK_MAX
//    moves to IDLE, sets last_gnt = i, and pulses lock_err the next cycle.
//  - last_gnt updates on every grant.
//  - Read return: a grant with wen = 0 is recorded as {valid, port} in one
//    pipeline stage. Next cycle: rvalid[port] = 1 and rdata = mem_rdata.
//    Latency 1. Writes never raise rvalid. Back-to-back reads give
//    back-to-back rvalid.
//  - Simultaneous read/write cannot collide: one access per cycle.
//  - Address is passed through unchanged; no wrap logic; the requester owns
//    address arithmetic.
//  - Reset mid-operation: pending rvalid is dropped; ownership is lost.
// STRUCTURE
//  - Shared package mem_pkg: ADDR_W/DATA_W constants, owner encoding
//    (OWN_NONE, OWN_P0, OWN_P1), CMD_WRITE = 8'h02, CMD_READ = 8'h03,
//    CMD_ADD = 8'h10, CMD_MUL = 8'h12.
//  - One sub-module, rr_lock_arb: owner FSM, last_gnt, lock_cnt, gnt
//    generation.
//  - Top level: datapath mux and read-return pipeline.
// TESTING
//  1. Port 0 writes 32'h12345678 @ 12'h0F0. Next cycle port 1 reads 12'h0F0
//     -> gnt = 2'b01 then 2'b10; rvalid = 2'b10 one cycle later;
//     rdata = 32'h12345678.
//  2. After reset, both ports request reads of 12'h0F0 and 12'h0F1 every
//     cycle -> gnt = 01,10,01,10...; rvalid alternates with correct data.
//  3. Port 0 runs a locked ADD (lock = 1: rd 0F0, rd 0F1; lock = 0: wr 0F2 =
//     32'h99999999) while port 1 requests a read of 0F2 -> port 1 granted
//     only after the write; it reads 32'h99999999.
//  4. Port 0 holds lock = 1 with req = 1 for 6 cycles; port 1 is pending ->
//     4 grants to port 0, then gnt = 2'b10 and one lock_err pulse.
//  5. Read granted to port 1, then rst_n = 0 for the next cycle -> rvalid
//     stays 0 and all outputs hold reset values; a fresh request after
//     release gets normal service.
//  6. No requests for 10 cycles -> mem_cen = 0, gnt = 0, rvalid = 0
//     throughout.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and encodings for the program-memory port arbiter.
package mem_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_ADD   = 8'h10;
    localparam logic [7:0] CMD_MUL   = 8'h12;

    function automatic owner_e own_of(input logic port);
        return port ? OWN_P1 : OWN_P0;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle: two ports' access requests plus grant and read return.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
);
    logic [1:0]          req;
    logic [1:0]          lock;
    logic [1:0]          req_wen;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                lock_err;

    modport master (
        output req, lock, req_wen, req_addr, req_wdata,
        input  gnt, rvalid, rdata, lock_err
    );

    modport slave (
        input  req, lock, req_wen, req_addr, req_wdata,
        output gnt, rvalid, rdata, lock_err
    );
endinterface

// File: rtl/rr_lock_arb.sv
// Two-port round-robin arbiter with ownership lock and a bounded lock length.
module rr_lock_arb
    import mem_pkg::*;
#(
    parameter int LOCK_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt,
    output logic       lock_err
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    owner_e           owner;
    logic             last_gnt;
    logic [CNT_W-1:0] lock_cnt;
    logic             own_idx;
    logic             gi;
    logic [1:0]       gnt_raw;

    assign own_idx = (owner == OWN_P1);

    always_comb begin
        gnt_raw = 2'b00;
        if (owner == OWN_NONE) begin
            if (req == 2'b11) gnt_raw = last_gnt ? 2'b01 : 2'b10;
            else              gnt_raw = req;
        end else if (req[own_idx]) begin
            gnt_raw[own_idx] = 1'b1;
        end
    end

    // No access may reach the memory while reset is being sampled.
    assign gnt = rst_n ? gnt_raw : 2'b00;
    assign gi  = gnt[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner    <= OWN_NONE;
            last_gnt <= 1'b1;
            lock_cnt <= '0;
            lock_err <= 1'b0;
        end else begin
            lock_err <= 1'b0;
            if (|gnt) last_gnt <= gi;
            case (owner)
                OWN_NONE: begin
                    if (|gnt && lock[gi]) begin
                        owner    <= own_of(gi);
                        lock_cnt <= CNT_W'(1);
                    end
                end
                default: begin
                    if (gnt[own_idx]) begin
                        if (!lock[own_idx]) begin
                            owner    <= OWN_NONE;
                            lock_cnt <= '0;
                        end else if (lock_cnt + 1'b1 == CNT_W'(LOCK_MAX)) begin
                            owner    <= OWN_NONE;
                            lock_cnt <= '0;
                            lock_err <= 1'b1;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end else if (!req[own_idx] && !lock[own_idx]) begin
                        owner    <= OWN_NONE;
                        lock_cnt <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port program memory between the command engine (port 0)
// and the debug/loader port (port 1); returns read data with 1-cycle latency.
module mem_port_arbiter #(
    parameter int ADDR_W   = mem_pkg::ADDR_W,
    parameter int DATA_W   = mem_pkg::DATA_W,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic              mem_cen
);
    logic [1:0] gnt;
    logic       lock_err_q;
    logic       gsel;
    logic       rd_vld;
    logic       rd_port;

    rr_lock_arb #(.LOCK_MAX(LOCK_MAX)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus.req),
        .lock     (bus.lock),
        .gnt      (gnt),
        .lock_err (lock_err_q)
    );

    assign gsel      = gnt[1];
    assign mem_cen   = |gnt;
    assign mem_wen   = mem_cen & bus.req_wen[gsel];
    assign mem_addr  = gsel ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
    assign mem_wdata = gsel ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];

    // Remember who issued the read so the returning word goes to that port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld  <= 1'b0;
            rd_port <= 1'b0;
        end else begin
            rd_vld  <= mem_cen & ~bus.req_wen[gsel];
            rd_port <= gsel;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rvalid   = (rst_n && rd_vld) ? (rd_port ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rdata    = (rst_n && rd_vld) ? mem_rdata : '0;
    assign bus.lock_err = rst_n & lock_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a rule-level arbiter model.
module tb_mem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LOCK_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_wen, mem_cen;

    logic [DW-1:0] mem    [4096];
    logic [DW-1:0] shadow [4096];
    int n_checks = 0;
    int n_fail = 0;

    // reference model state: owner -1 = none
    int m_owner, m_last, m_cnt, m_rport;
    bit m_rpend, m_err;
    logic [DW-1:0] m_rdata;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_cen(mem_cen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) mem[mem_addr] <= mem_wdata;
            else         mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        bus.req = r; bus.lock = l; bus.req_wen = w;
        bus.req_addr = {a1, a0}; bus.req_wdata = {w1, w0};
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drv(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic m_reset();
        m_owner = -1; m_last = 1; m_cnt = 0; m_rpend = 0; m_err = 0; m_rport = 0; m_rdata = '0;
    endtask

    function automatic logic [1:0] m_gnt(input logic [1:0] r);
        if (m_owner < 0) begin
            if (r == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
            return r;
        end
        if (!r[m_owner]) return 2'b00;
        return (m_owner == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic m_update(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [1:0] g);
        int gi;
        logic [AW-1:0] a;
        gi = g[0] ? 0 : (g[1] ? 1 : -1);
        m_rpend = 0; m_err = 0;
        if (gi >= 0) begin
            a = gi ? a1 : a0;
            if (w[gi]) shadow[a] = gi ? d1 : d0;
            else begin m_rpend = 1; m_rport = gi; m_rdata = shadow[a]; end
            m_last = gi;
        end
        if (m_owner < 0) begin
            if (gi >= 0 && l[gi]) begin m_owner = gi; m_cnt = 1; end
        end else if (gi == m_owner) begin
            if (!l[gi]) m_owner = -1;
            else begin
                m_cnt++;
                if (m_cnt == LOCK_MAX) begin m_owner = -1; m_err = 1; end
            end
        end else if (!r[m_owner] && !l[m_owner]) begin
            m_owner = -1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drv(2'b11, 2'b11, 2'b00, 12'h0F0, 12'h0F1, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.gnt, bus.rvalid, bus.lock_err, mem_cen, mem_wen} !== 7'b0 || bus.rdata !== '0) begin
                n_fail++;
                $display("FAIL reset c%0d: gnt=%b rvalid=%b lock_err=%b cen=%b wen=%b rdata=%h, want all 0",
                         i, bus.gnt, bus.rvalid, bus.lock_err, mem_cen, mem_wen, bus.rdata);
            end
            step();
        end
        drv(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        apply_reset();
        drv(2'b01, 2'b00, 2'b01, 12'h0F0, '0, 32'h12345678, '0);
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 2'b01 || {mem_cen, mem_wen} !== 2'b11 || mem_addr !== 12'h0F0 || mem_wdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wr_grant: gnt=%b cen=%b wen=%b addr=%h wdata=%h, want 01 1 1 0f0 12345678",
                     bus.gnt, mem_cen, mem_wen, mem_addr, mem_wdata);
        end
        step();
        drv(2'b10, 2'b00, 2'b00, '0, 12'h0F0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 2'b10 || mem_wen !== 1'b0 || mem_addr !== 12'h0F0 || bus.rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_grant: gnt=%b wen=%b addr=%h rvalid=%b, want 10 0 0f0 00", bus.gnt, mem_wen, mem_addr, bus.rvalid);
        end
        step();
        drv(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (bus.rvalid !== 2'b10 || bus.rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rd_return: rvalid=%b rdata=%h, want 10 12345678", bus.rvalid, bus.rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d0, d1;
        logic [1:0] eg, erv;
        d0 = $urandom; d1 = $urandom;
        drv(2'b01, 2'b00, 2'b01, 12'h0F0, '0, d0, '0); step();
        drv(2'b01, 2'b00, 2'b01, 12'h0F1, '0, d1, '0); step();
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            if (k < 8) drv(2'b11, 2'b00, 2'b00, 12'h0F0, 12'h0F1, '0, '0);
            else       drv(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
            eg  = (k == 8) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01);
            erv = (k % 2 == 1) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg) begin
                n_fail++;
                $display("FAIL b2b_gnt c%0d: gnt=%b, want %b", k, bus.gnt, eg);
            end
            if (k > 0) begin
                n_checks++;
                if (bus.rvalid !== erv || bus.rdata !== (erv[0] ? d0 : d1)) begin
                    n_fail++;
                    $display("FAIL b2b_rd c%0d: rvalid=%b rdata=%h, want %b %h", k, bus.rvalid, bus.rdata, erv, erv[0] ? d0 : d1);
                end
            end
            step();
        end
    endtask

    task automatic test_locked_add();
        logic [1:0] eg, erv;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: drv(2'b11, 2'b01, 2'b00, 12'h0F0, 12'h0F2, '0, '0);
                1: drv(2'b11, 2'b01, 2'b00, 12'h0F1, 12'h0F2, '0, '0);
                2: drv(2'b11, 2'b00, 2'b01, 12'h0F2, 12'h0F2, 32'h99999999, '0);
                3: drv(2'b10, 2'b00, 2'b00, '0, 12'h0F2, '0, '0);
                default: drv(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
            endcase
            eg  = (k < 3) ? 2'b01 : ((k == 3) ? 2'b10 : 2'b00);
            erv = (k == 1 || k == 2) ? 2'b01 : ((k == 4) ? 2'b10 : 2'b00);
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg || bus.rvalid !== erv) begin
                n_fail++;
                $display("FAIL add_lock c%0d: gnt=%b rvalid=%b, want %b %b", k, bus.gnt, bus.rvalid, eg, erv);
            end
            if (k == 4) begin
                n_checks++;
                if (bus.rdata !== 32'h99999999) begin
                    n_fail++;
                    $display("FAIL add_rdata: rdata=%h, want 99999999", bus.rdata);
                end
            end
            step();
        end
    endtask

    task automatic test_forced_release();
        logic [1:0] eg;
        logic ee;
        int pulses;
        pulses = 0;
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            if (k < 5)       drv(2'b11, 2'b01, 2'b00, 12'h010, 12'h020, '0, '0);
            else if (k == 5) drv(2'b01, 2'b01, 2'b00, 12'h010, '0, '0, '0);
            else             drv(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
            eg = (k < 4 || k == 5) ? 2'b01 : ((k == 4) ? 2'b10 : 2'b00);
            ee = (k == 4);
            @(negedge clk);
            if (bus.lock_err === 1'b1) pulses++;
            n_checks++;
            if (bus.gnt !== eg || bus.lock_err !== ee) begin
                n_fail++;
                $display("FAIL forced c%0d: gnt=%b lock_err=%b, want %b %b", k, bus.gnt, bus.lock_err, eg, ee);
            end
            step();
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL forced_pulses: saw %0d lock_err pulses, want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drv(2'b10, 2'b00, 2'b00, '0, 12'h0F2, '0, '0);
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL rstmid_gnt: gnt=%b, want 10", bus.gnt);
        end
        step();
        rst_n = 1'b0;
        drv(2'b11, 2'b11, 2'b00, 12'h0F0, 12'h0F2, '0, '0);
        @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.rvalid, bus.lock_err, mem_cen, mem_wen} !== 7'b0 || bus.rdata !== '0) begin
            n_fail++;
            $display("FAIL rstmid_hold: gnt=%b rvalid=%b lock_err=%b cen=%b rdata=%h, want all 0",
                     bus.gnt, bus.rvalid, bus.lock_err, mem_cen, bus.rdata);
        end
        step();
        rst_n = 1'b1;
        drv(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (bus.rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_drop: rvalid=%b, want 00", bus.rvalid);
        end
        step();
        drv(2'b10, 2'b00, 2'b00, '0, 12'h0F2, '0, '0);
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL rstmid_regnt: gnt=%b, want 10", bus.gnt);
        end
        step();
        drv(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (bus.rvalid !== 2'b10 || bus.rdata !== 32'h99999999) begin
            n_fail++;
            $display("FAIL rstmid_rd: rvalid=%b rdata=%h, want 10 99999999", bus.rvalid, bus.rdata);
        end
        step();
    endtask

    task automatic test_idle();
        drv(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.gnt, bus.rvalid, mem_cen} !== 5'b0) begin
                n_fail++;
                $display("FAIL idle c%0d: gnt=%b rvalid=%b cen=%b, want 0", k, bus.gnt, bus.rvalid, mem_cen);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [1:0] pr, pl, pw, hold, eg, erv;
        logic [AW-1:0] pa [2];
        logic [DW-1:0] pd [2];
        logic [DW-1:0] erd;
        logic eerr;
        int gi;
        pr = '0; pl = '0; pw = '0; hold = '0;
        pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
        apply_reset();
        m_reset();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pr[p] && (hold[p] || $urandom_range(0, 2) != 0)) begin
                    pr[p] = 1'b1;
                    pw[p] = 1'($urandom_range(0, 1));
                    pl[p] = hold[p] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
                    pa[p] = AW'($urandom_range(0, 15));
                    pd[p] = $urandom;
                end
            end
            drv(pr, pl, pw, pa[0], pa[1], pd[0], pd[1]);
            eg   = m_gnt(pr);
            erv  = m_rpend ? ((m_rport == 1) ? 2'b10 : 2'b01) : 2'b00;
            erd  = m_rdata;
            eerr = m_err;
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg || mem_cen !== (|eg) || bus.lock_err !== eerr || bus.rvalid !== erv) begin
                n_fail++;
                $display("FAIL rand_ctl c%0d: gnt=%b cen=%b lock_err=%b rvalid=%b, want %b %b %b %b",
                         c, bus.gnt, mem_cen, bus.lock_err, bus.rvalid, eg, |eg, eerr, erv);
            end
            if (erv != 2'b00) begin
                n_checks++;
                if (bus.rdata !== erd) begin
                    n_fail++;
                    $display("FAIL rand_rdata c%0d: rdata=%h, want %h", c, bus.rdata, erd);
                end
            end
            if (eg != 2'b00) begin
                gi = eg[1] ? 1 : 0;
                n_checks++;
                if (mem_addr !== pa[gi] || mem_wen !== pw[gi] || (pw[gi] && mem_wdata !== pd[gi])) begin
                    n_fail++;
                    $display("FAIL rand_mem c%0d: addr=%h wen=%b wdata=%h, want %h %b %h",
                             c, mem_addr, mem_wen, mem_wdata, pa[gi], pw[gi], pd[gi]);
                end
            end
            m_update(pr, pl, pw, pa[0], pa[1], pd[0], pd[1], eg);
            for (int p = 0; p < 2; p++) begin
                if (eg[p]) begin hold[p] = pl[p]; pr[p] = 1'b0; pl[p] = 1'b0; end
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        drv(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_locked_add();
        test_forced_release();
        test_reset_mid();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
